// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with runtime divisor/parity, 3-sample majority voting at mid-bit
// and a valid/ready output register. Define UART_RX_CFG_PARITY_EN to build the parity stage.
module uart_rx_cfg #(
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned DIV_W        = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  input  logic [DIV_W-1:0]        cfg_div,
  input  logic [1:0]              cfg_parity,
  input  logic                    uart_rx_ready,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_perr,
  output logic                    uart_rx_ferr,
  output logic                    uart_rx_break,
  output logic                    uart_rx_overrun,
  output logic                    uart_rx_busy
);

  localparam int unsigned IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_CFG_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic                    rx_meta, rxs;
  logic [DIV_W-1:0]        div_q, cnt_q, half_c;
  logic [IDX_W-1:0]        idx_q;
  logic                    s0_q, s1_q, armed_q;
  logic [PAYLOAD_BITS-1:0] shreg_q;
  logic                    ferr_q, nz_q;
  logic                    last_c, dec_c, maj_c, done_c;

`ifdef UART_RX_CFG_PARITY_EN
  logic [1:0] par_q;
  logic       perr_q;
  logic       par_en_c;
  assign par_en_c = (par_q == 2'b01) || (par_q == 2'b10);
`else
  logic unused_cfg_parity;
  assign unused_cfg_parity = ^cfg_parity;
  assign uart_rx_perr      = 1'b0;
`endif

  assign half_c = div_q >> 1;
  assign last_c = (cnt_q == div_q - DIV_W'(1));
  assign dec_c  = (cnt_q == half_c + DIV_W'(1));
  assign maj_c  = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    if (!uart_rx_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (armed_q && !rxs) state_d = S_START;
        S_START: begin
          if (dec_c && maj_c) state_d = S_IDLE;
          else if (last_c)    state_d = S_DATA;
        end
        S_DATA: begin
          if (last_c && idx_q == IDX_W'(PAYLOAD_BITS - 1)) begin
`ifdef UART_RX_CFG_PARITY_EN
            state_d = par_en_c ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef UART_RX_CFG_PARITY_EN
        S_PARITY: if (last_c) state_d = S_STOP;
`endif
        S_STOP: begin
          // Final stop bit completes at its decision point to leave slack for a fast sender
          if (dec_c && idx_q == IDX_W'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            done_c  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q           <= '0;
      cnt_q           <= '0;
      idx_q           <= '0;
      s0_q            <= 1'b1;
      s1_q            <= 1'b1;
      armed_q         <= 1'b0;
      shreg_q         <= '0;
      ferr_q          <= 1'b0;
      nz_q            <= 1'b0;
      uart_rx_valid   <= 1'b0;
      uart_rx_data    <= '0;
      uart_rx_ferr    <= 1'b0;
      uart_rx_break   <= 1'b0;
      uart_rx_overrun <= 1'b0;
      uart_rx_busy    <= 1'b0;
`ifdef UART_RX_CFG_PARITY_EN
      par_q           <= 2'b00;
      perr_q          <= 1'b0;
      uart_rx_perr    <= 1'b0;
`endif
    end else if (!uart_rx_en) begin
      cnt_q           <= '0;
      idx_q           <= '0;
      armed_q         <= 1'b0;
      uart_rx_valid   <= 1'b0;
      uart_rx_data    <= '0;
      uart_rx_ferr    <= 1'b0;
      uart_rx_break   <= 1'b0;
      uart_rx_overrun <= 1'b0;
      uart_rx_busy    <= 1'b0;
`ifdef UART_RX_CFG_PARITY_EN
      uart_rx_perr    <= 1'b0;
`endif
    end else begin
      uart_rx_busy <= (state_d != S_IDLE);

      if (state_q == S_IDLE || last_c) cnt_q <= '0;
      else                             cnt_q <= cnt_q + DIV_W'(1);

      if (state_d != state_q) idx_q <= '0;
      else if (last_c)        idx_q <= idx_q + IDX_W'(1);

      if (cnt_q == half_c - DIV_W'(1)) s0_q <= rxs;
      if (cnt_q == half_c)             s1_q <= rxs;

      // Frame configuration is frozen at start detect
      if (state_q == S_IDLE && state_d == S_START) begin
        div_q  <= cfg_div;
        ferr_q <= 1'b0;
        nz_q   <= 1'b0;
`ifdef UART_RX_CFG_PARITY_EN
        par_q  <= cfg_parity;
        perr_q <= 1'b0;
`endif
      end

      if (dec_c) begin
        case (state_q)
          S_DATA: begin
            shreg_q <= {maj_c, shreg_q[PAYLOAD_BITS-1:1]};
            nz_q    <= nz_q | maj_c;
          end
`ifdef UART_RX_CFG_PARITY_EN
          S_PARITY: begin
            perr_q <= (^shreg_q) ^ maj_c ^ (par_q == 2'b10);
            nz_q   <= nz_q | maj_c;
          end
`endif
          S_STOP: begin
            ferr_q <= ferr_q | ~maj_c;
            nz_q   <= nz_q | maj_c;
          end
          default: ;
        endcase
      end

      // A line stuck low after a framing error must go high before the next start
      if (state_q == S_IDLE && rxs)             armed_q <= 1'b1;
      else if (done_c && (ferr_q || !maj_c))    armed_q <= 1'b0;

      if (done_c) begin
        uart_rx_valid   <= 1'b1;
        uart_rx_data    <= shreg_q;
        uart_rx_ferr    <= ferr_q | ~maj_c;
        uart_rx_break   <= ~(nz_q | maj_c);
        uart_rx_overrun <= uart_rx_valid & ~uart_rx_ready;
`ifdef UART_RX_CFG_PARITY_EN
        uart_rx_perr    <= perr_q;
`endif
      end else if (uart_rx_valid && uart_rx_ready) begin
        uart_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: vector table, directed corner sequences and random frames for uart_rx_cfg,
// checked against a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int unsigned PB = 8;
  localparam int unsigned SB = 1;
  localparam int unsigned DW = 16;
`ifdef UART_RX_CFG_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn, uart_rxd, uart_rx_en, uart_rx_ready;
  logic [DW-1:0] cfg_div;
  logic [1:0]    cfg_parity;
  logic          uart_rx_valid, uart_rx_perr, uart_rx_ferr, uart_rx_break;
  logic          uart_rx_overrun, uart_rx_busy;
  logic [PB-1:0] uart_rx_data;

  always #5 clk = ~clk;

  uart_rx_cfg #(.PAYLOAD_BITS(PB), .STOP_BITS(SB), .DIV_W(DW)) dut (
    .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
    .cfg_div(cfg_div), .cfg_parity(cfg_parity), .uart_rx_ready(uart_rx_ready),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_perr(uart_rx_perr),
    .uart_rx_ferr(uart_rx_ferr), .uart_rx_break(uart_rx_break),
    .uart_rx_overrun(uart_rx_overrun), .uart_rx_busy(uart_rx_busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    logic       ovr;
  } rec_t;

  typedef struct {
    int         div;
    int         mode;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    rec_t       exp;
  } vec_t;

  rec_t cap_q[$];
  int   vcnt   = 0;
  int   errors = 0;
  int   checks = 0;

  // Records every transfer and counts every cycle valid is high
  always @(negedge clk) begin
    rec_t r;
    if (uart_rx_valid) vcnt++;
    if (uart_rx_valid && uart_rx_ready) begin
      r.data = uart_rx_data;
      r.perr = uart_rx_perr;
      r.ferr = uart_rx_ferr;
      r.brk  = uart_rx_break;
      r.ovr  = uart_rx_overrun;
      cap_q.push_back(r);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input logic b, input int n);
    uart_rxd = b;
    repeat (n) tick();
  endtask

  function automatic bit par_active(input int mode);
    return PE && (mode == 1 || mode == 2);
  endfunction

  function automatic rec_t mk(input logic [7:0] d, input logic pe, input logic fe, input logic bk);
    rec_t r;
    r.data = d; r.perr = pe; r.ferr = fe; r.brk = bk; r.ovr = 1'b0;
    return r;
  endfunction

  // Frame-level reference: what a receiver must report for a given transmitted frame
  function automatic rec_t model(input int mode, input logic [7:0] d, input logic p, input logic s);
    bit act;
    int ones;
    act  = par_active(mode);
    ones = $countones(d) + ((act && p) ? 1 : 0);
    return mk(d, act && ((ones % 2) != ((mode == 2) ? 1 : 0)), !s,
              (d == 8'h00) && !(act && p) && !s);
  endfunction

  task automatic send_frame(input int div, input int mode, input logic [7:0] d,
                            input logic p, input logic s);
    cfg_div    = DW'(div);
    cfg_parity = 2'(mode);
    drive_bit(1'b0, div);
    for (int i = 0; i < 8; i++) drive_bit(d[i], div);
    if (par_active(mode)) drive_bit(p, div);
    drive_bit(s, div);
    drive_bit(1'b1, 2 * div);
  endtask

  task automatic get_frame(input string name, input int bound, output rec_t r);
    bit ok = 1'b0;
    r = '0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (cap_q.size() > 0) begin
        r  = cap_q.pop_front();
        ok = 1'b1;
      end else begin
        tick();
      end
    end
    check({name, " arrival"}, 32'(ok), 32'd1);
  endtask

  vec_t       tbl[9];
  rec_t       r, e;
  int         div, mode, v0, t_rise, t_fall;
  logic [7:0] d;
  logic       p, s;

  initial begin
    tbl[0] = '{8,  0, 8'hA5, 1'b0, 1'b1, mk(8'hA5, 1'b0, 1'b0, 1'b0)};
    tbl[1] = '{16, 1, 8'h07, 1'b1, 1'b1, mk(8'h07, 1'b0, 1'b0, 1'b0)};
    tbl[2] = '{16, 1, 8'h07, 1'b0, 1'b1, mk(8'h07, PE,   1'b0, 1'b0)};
    tbl[3] = '{12, 2, 8'h07, 1'b0, 1'b1, mk(8'h07, 1'b0, 1'b0, 1'b0)};
    tbl[4] = '{10, 2, 8'h0F, 1'b0, 1'b1, mk(8'h0F, PE,   1'b0, 1'b0)};
    tbl[5] = '{4,  0, 8'hFF, 1'b0, 1'b1, mk(8'hFF, 1'b0, 1'b0, 1'b0)};
    tbl[6] = '{9,  0, 8'h3C, 1'b0, 1'b0, mk(8'h3C, 1'b0, 1'b1, 1'b0)};
    tbl[7] = '{8,  0, 8'h00, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b1, 1'b1)};
    tbl[8] = '{5,  3, 8'h81, 1'b0, 1'b1, mk(8'h81, 1'b0, 1'b0, 1'b0)};

    resetn = 1'b0; uart_rx_en = 1'b1; uart_rxd = 1'b1; uart_rx_ready = 1'b1;
    cfg_div = DW'(8); cfg_parity = 2'b00;
    repeat (3) tick();
    check("reset outputs", {uart_rx_valid, uart_rx_data, uart_rx_perr, uart_rx_ferr,
          uart_rx_break, uart_rx_overrun, uart_rx_busy}, 32'd0);
    resetn = 1'b1;
    repeat (5) tick();
    check("idle outputs", {uart_rx_valid, uart_rx_data, uart_rx_perr, uart_rx_ferr,
          uart_rx_break, uart_rx_overrun, uart_rx_busy}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      send_frame(tbl[i].div, tbl[i].mode, tbl[i].data, tbl[i].pbit, tbl[i].stop);
      get_frame($sformatf("vec%0d", i), 200, r);
      check($sformatf("vec%0d frame", i), 32'(r), 32'(tbl[i].exp));
    end
    check("table busy idle", 32'(uart_rx_busy), 32'd0);
    check("table no extra frames", 32'(cap_q.size()), 32'd0);

    // Break: line low for 12 bit times gives exactly one frame
    uart_rxd = 1'b0; cfg_div = DW'(8); cfg_parity = 2'b00;
    repeat (12 * 8) tick();
    uart_rxd = 1'b1;
    repeat (4 * 8) tick();
    check("break count", 32'(cap_q.size()), 32'd1);
    r = (cap_q.size() > 0) ? cap_q.pop_front() : '0;
    check("break frame", 32'(r), 32'(mk(8'h00, 1'b0, 1'b1, 1'b1)));
    cap_q.delete();

    // Overrun: two frames without a consumer
    uart_rx_ready = 1'b0;
    send_frame(8, 0, 8'h11, 1'b0, 1'b1);
    check("ovr first", {uart_rx_valid, uart_rx_data, uart_rx_overrun}, {1'b1, 8'h11, 1'b0});
    send_frame(8, 0, 8'h22, 1'b0, 1'b1);
    check("ovr second", {uart_rx_valid, uart_rx_data, uart_rx_overrun}, {1'b1, 8'h22, 1'b1});
    uart_rx_ready = 1'b1;
    tick();
    check("ovr valid drop", 32'(uart_rx_valid), 32'd0);
    repeat (4) tick();
    check("ovr transfers", 32'(cap_q.size()), 32'd1);
    r = (cap_q.size() > 0) ? cap_q.pop_front() : '0;
    check("ovr frame", 32'({r.data, r.ovr}), 32'({8'h22, 1'b1}));

    // False start: 2-cycle glitch
    cfg_div = DW'(16); v0 = vcnt; t_rise = -1; t_fall = -1;
    uart_rxd = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 3) uart_rxd = 1'b1;
      tick();
      if (uart_rx_busy && t_rise < 0) t_rise = i;
      if (!uart_rx_busy && t_rise >= 0 && t_fall < 0) t_fall = i;
    end
    check("glitch busy seen", 32'(t_rise >= 0 && t_fall >= 0), 32'd1);
    check("glitch busy window", 32'(t_fall - t_rise <= 11), 32'd1);
    check("glitch no valid", 32'(vcnt - v0), 32'd0);
    send_frame(16, 0, 8'h3C, 1'b0, 1'b1);
    get_frame("after glitch", 200, r);
    check("after glitch frame", 32'(r), 32'(mk(8'h3C, 1'b0, 1'b0, 1'b0)));

    // Reset mid-DATA
    cfg_div = DW'(8); cfg_parity = 2'b00;
    drive_bit(1'b0, 8); drive_bit(1'b0, 8); drive_bit(1'b1, 8); drive_bit(1'b0, 4);
    check("abort busy before", 32'(uart_rx_busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("abort outputs", {uart_rx_valid, uart_rx_data, uart_rx_perr, uart_rx_ferr,
          uart_rx_break, uart_rx_overrun, uart_rx_busy}, 32'd0);
    uart_rxd = 1'b1;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (20) tick();

    // Disable mid-frame
    v0 = vcnt;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(((8'h5A >> i) & 8'h01) != 0, 8);
    uart_rx_en = 1'b0;
    tick();
    check("disable busy", 32'(uart_rx_busy), 32'd0);
    for (int i = 4; i < 8; i++) drive_bit(((8'h5A >> i) & 8'h01) != 0, 8);
    drive_bit(1'b1, 24);
    check("disable no valid", 32'(vcnt - v0), 32'd0);
    uart_rx_en = 1'b1;
    repeat (4) tick();
    send_frame(8, 0, 8'h5A, 1'b0, 1'b1);
    get_frame("recovery", 200, r);
    check("recovery frame", 32'(r), 32'(mk(8'h5A, 1'b0, 1'b0, 1'b0)));

    // Random frames against the reference model
    for (int n = 0; n < 24; n++) begin
      div  = $urandom_range(20, 4);
      mode = $urandom_range(3, 0);
      d    = 8'($urandom);
      if (n % 6 == 0) d = 8'h00;
      p    = 1'($urandom_range(1, 0));
      s    = ($urandom_range(4, 0) != 0);
      e    = model(mode, d, p, s);
      send_frame(div, mode, d, p, s);
      get_frame($sformatf("rnd%0d", n), 200, r);
      check($sformatf("rnd%0d frame div=%0d mode=%0d", n, div, mode), 32'(r), 32'(e));
    end
    check("random no extra frames", 32'(cap_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
